// File: rtl/seq_multiplier.sv
// Sequential radix-2 shift-add multiplier with optional accumulate.
// Modes: MUL (low word), UMULL, SMULL (sign-magnitude with final
// negate), reserved mode 11 behaves as UMULL. Fixed latency: an accepted
// start runs WIDTH CALC cycles, one FIX cycle, then a one-cycle DONE.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             accumulate,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] acc_hi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [1:0]       flags
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = 2 * WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Operation attributes latched at accept time; the running op never
  // looks at the live inputs again.
  typedef struct packed {
    logic          long_op;  // write both words (UMULL/SMULL/reserved)
    logic          neg;      // signed mode and operand signs differ
    logic          accum;    // add accumulator in FIX
    logic [PW-1:0] acc;      // {acc_hi, acc_lo}
  } op_t;

  logic [1:0]       state;
  op_t              op_q;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last_iter;
  logic             is_signed;
  logic             is_long;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [PW-1:0]    fixed_prod;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    final_v;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;
  logic             res_n;
  logic             res_z;

  // Start is honoured only when no operation is in flight.
  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign last_iter = (cnt == CW'(WIDTH - 1));

  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);

  // Operand conditioning: signed mode multiplies magnitudes. The most
  // negative value negates to itself, which read as unsigned is exactly
  // its magnitude 2^(WIDTH-1), so no special case is needed.
  always_comb begin
    is_signed = (mode == 2'b10);
    is_long   = (mode != 2'b00);
    a_neg     = is_signed && srca[WIDTH-1];
    b_neg     = is_signed && srcb[WIDTH-1];
    a_mag     = a_neg ? (~srca + 1'b1) : srca;
    b_mag     = b_neg ? (~srcb + 1'b1) : srcb;
  end

  // FIX-stage result: restore the sign, then add the accumulator.
  // MUL only adds acc_lo and only the low word is architecturally visible.
  always_comb begin
    fixed_prod = op_q.neg ? (~prod + 1'b1) : prod;
    addend     = '0;
    if (op_q.accum) begin
      if (op_q.long_op) addend = op_q.acc;
      else              addend = {{WIDTH{1'b0}}, op_q.acc[WIDTH-1:0]};
    end
    final_v = fixed_prod + addend;
    res_lo  = final_v[WIDTH-1:0];
    res_hi  = op_q.long_op ? final_v[PW-1:WIDTH] : '0;
    res_n   = op_q.long_op ? res_hi[WIDTH-1] : res_lo[WIDTH-1];
    res_z   = op_q.long_op ? (final_v == '0) : (res_lo == '0);
  end

  // Control FSM: IDLE/DONE -> CALC on accept, CALC for WIDTH cycles,
  // one FIX cycle, one DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    state <= accept ? CALC : IDLE;
        CALC:    state <= last_iter ? FIX : CALC;
        FIX:     state <= DONE;
        DONE:    state <= accept ? CALC : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: load on accept, one multiplier bit per CALC cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= '0;
      mcand  <= '0;
      prod   <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (accept) begin
      op_q.long_op <= is_long;
      op_q.neg     <= a_neg ^ b_neg;
      op_q.accum   <= accumulate;
      op_q.acc     <= {acc_hi, acc_lo};
      mcand        <= {{WIDTH{1'b0}}, a_mag};
      mplier       <= b_mag;
      prod         <= '0;
      cnt          <= '0;
    end else if (state == CALC) begin
      if (mplier[0]) prod <= prod + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  // Architectural results change only when FIX hands over to DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_lo <= '0;
      result_hi <= '0;
      flags     <= '0;
    end else if (state == FIX) begin
      result_lo <= res_lo;
      result_hi <= res_hi;
      flags     <= {res_n, res_z};
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: a WIDTH=32 and a WIDTH=8
// instance share inputs; expected results come from a plain-arithmetic
// model of the multiply/accumulate rules.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic        start32, start8;
  logic [1:0]  mode;
  logic        accumulate;
  logic [31:0] srca, srcb, acc_lo, acc_hi;

  logic        busy32, done32, busy8, done8;
  logic [31:0] lo32, hi32;
  logic [7:0]  lo8, hi8;
  logic [1:0]  fl32, fl8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .mode(mode),
    .accumulate(accumulate), .srca(srca), .srcb(srcb),
    .acc_lo(acc_lo), .acc_hi(acc_hi), .busy(busy32), .done(done32),
    .result_lo(lo32), .result_hi(hi32), .flags(fl32)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .mode(mode),
    .accumulate(accumulate), .srca(srca[7:0]), .srcb(srcb[7:0]),
    .acc_lo(acc_lo[7:0]), .acc_hi(acc_hi[7:0]), .busy(busy8), .done(done8),
    .result_lo(lo8), .result_hi(hi8), .flags(fl8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: signed/unsigned product of w-bit operands, plus accumulator,
  // reduced modulo the visible result width.
  function automatic void model(input int w, input logic [1:0] m, input logic ac,
                                input logic [31:0] a32, b32, alo32, ahi32,
                                output logic [63:0] lo, hi, output logic [1:0] fl);
    logic [63:0] mask, fmask, a, b, alo, ahi, p, full;
    longint sa, sb;
    mask  = (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFF;
    fmask = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF;
    a   = {32'b0, a32} & mask;
    b   = {32'b0, b32} & mask;
    alo = {32'b0, alo32} & mask;
    ahi = {32'b0, ahi32} & mask;
    if (m == 2'b10) begin
      sa = a[w-1] ? longint'(a | ~mask) : longint'(a);
      sb = b[w-1] ? longint'(b | ~mask) : longint'(b);
      p  = 64'(sa * sb);
    end else begin
      p = a * b;
    end
    if (m == 2'b00) begin
      lo = (p + (ac ? alo : 64'd0)) & mask;
      hi = 64'd0;
      fl = {lo[w-1], lo == 64'd0};
    end else begin
      full = (p + (ac ? ((ahi << w) | alo) : 64'd0)) & fmask;
      lo   = full & mask;
      hi   = full >> w;
      fl   = {hi[w-1], full == 64'd0};
    end
  endfunction

  task automatic sample(input int w, output logic [63:0] lo, hi,
                        output logic [1:0] fl, output logic b, d);
    if (w == 32) begin
      lo = {32'b0, lo32}; hi = {32'b0, hi32}; fl = fl32; b = busy32; d = done32;
    end else begin
      lo = {56'b0, lo8}; hi = {56'b0, hi8}; fl = fl8; b = busy8; d = done8;
    end
  endtask

  task automatic set_start(input int w, input logic v);
    if (w == 32) start32 = v;
    else         start8  = v;
  endtask

  task automatic scramble();
    srca = $urandom; srcb = $urandom; acc_lo = $urandom; acc_hi = $urandom;
    mode = 2'($urandom); accumulate = 1'($urandom);
  endtask

  // One operation from start (cycle 0) to DONE (cycle w+2). Inputs are
  // scrambled every busy cycle; start may be re-pulsed in cycles p1/p2.
  task automatic run_op(input string tag, input int w, input logic [1:0] m,
                        input logic ac, input logic [31:0] a, b, alo, ahi,
                        input int p1, input int p2);
    logic [63:0] elo, ehi, glo, ghi;
    logic [1:0]  efl, gfl;
    logic        gb, gd;
    int ndone = 0, dcyc = -1, berr = 0;
    model(w, m, ac, a, b, alo, ahi, elo, ehi, efl);
    mode = m; accumulate = ac; srca = a; srcb = b; acc_lo = alo; acc_hi = ahi;
    set_start(w, 1'b1);
    for (int c = 1; c <= w + 2; c++) begin
      @(posedge clk); #1;
      sample(w, glo, ghi, gfl, gb, gd);
      if (gb !== (c <= w + 1)) berr++;
      if (gd === 1'b1) begin ndone++; dcyc = c; end
      scramble();
      set_start(w, (c == p1) || (c == p2));
    end
    chk({tag, ".lo"}, glo, elo);
    chk({tag, ".hi"}, ghi, ehi);
    chk({tag, ".flags"}, 64'(gfl), 64'(efl));
    chk({tag, ".ndone"}, 64'(ndone), 64'd1);
    chk({tag, ".donecyc"}, 64'(dcyc), 64'(w + 2));
    chk({tag, ".busyerr"}, 64'(berr), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    sample(w, glo, ghi, gfl, gb, gd);
    chk({tag, ".hold"}, glo, elo);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h0000_0080;
      default: return $urandom;
    endcase
  endfunction

  logic [63:0] glo, ghi, ealo, eahi, eblo, ebhi;
  logic [1:0]  gfl, eafl, ebfl;
  logic        gb, gd;
  int          ndone, berr;
  logic [1:0]  ma, mb;
  logic        aca, acb;
  logic [31:0] aa, ab, alo_a, ahi_a, ba, bb, alo_b, ahi_b;

  initial begin
    reset = 1'b1; start32 = 1'b0; start8 = 1'b0;
    mode = 2'b00; accumulate = 1'b0;
    srca = '0; srcb = '0; acc_lo = '0; acc_hi = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy32", 64'(busy32), 64'd0);
    chk("rst.done32", 64'(done32), 64'd0);
    chk("rst.res32", {hi32, lo32}, 64'd0);
    chk("rst.flags32", 64'(fl32), 64'd0);
    chk("rst.res8", {48'b0, hi8, lo8}, 64'd0);
    reset = 1'b0;

    run_op("mul7x6", 32, 2'b00, 1'b0, 32'd7, 32'd6, 32'd0, 32'd0, -1, -1);
    run_op("umull_ff", 32, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, -1, -1);
    run_op("smull_m2x3", 32, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, -1, -1);
    run_op("smlal_zero", 32, 2'b10, 1'b1, 32'hFFFF_FFFE, 32'd3, 32'd6, 32'd0, -1, -1);
    run_op("mla_wrap", 32, 2'b00, 1'b1, 32'h8000_0000, 32'd2, 32'd1, 32'd0, -1, -1);
    run_op("smull_minsq", 32, 2'b10, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, -1, -1);
    run_op("rsvd_mode", 32, 2'b11, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 32'h9, 32'h7, -1, -1);
    run_op("busy_start", 32, 2'b00, 1'b0, 32'd7, 32'd6, 32'd0, 32'd0, 5, 20);

    for (int i = 0; i < 12; i++)
      run_op("rnd32", 32, 2'($urandom), 1'($urandom), pick(), pick(), $urandom, $urandom, -1, -1);
    for (int i = 0; i < 10; i++)
      run_op("rnd8", 8, 2'($urandom), 1'($urandom), pick(), pick(), $urandom, $urandom, -1, -1);

    // Abort mid-CALC: reset (with start also high) in cycle 10.
    mode = 2'b01; accumulate = 1'b0; srca = 32'd5; srcb = 32'd9; start32 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start32 = 1'b0;
    end
    reset = 1'b1; start32 = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start32 = 1'b0;
    chk("abort.busy", 64'(busy32), 64'd0);
    chk("abort.done", 64'(done32), 64'd0);
    chk("abort.res", {hi32, lo32}, 64'd0);
    chk("abort.flags", 64'(fl32), 64'd0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done32 === 1'b1) ndone++;
    end
    chk("abort.nodone", 64'(ndone), 64'd0);

    // WIDTH=8 back-to-back: start held through the first DONE cycle.
    ma = 2'b10; aca = 1'b1; aa = 32'h83; ab = 32'h7F; alo_a = 32'h11; ahi_a = 32'h22;
    mb = 2'b01; acb = 1'b0; ba = 32'hF0; bb = 32'hEE; alo_b = 32'h55; ahi_b = 32'h66;
    model(8, ma, aca, aa, ab, alo_a, ahi_a, ealo, eahi, eafl);
    model(8, mb, acb, ba, bb, alo_b, ahi_b, eblo, ebhi, ebfl);
    mode = ma; accumulate = aca; srca = aa; srcb = ab; acc_lo = alo_a; acc_hi = ahi_a;
    start8 = 1'b1;
    ndone = 0; berr = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      sample(8, glo, ghi, gfl, gb, gd);
      if (gb !== ((c != 10) && (c != 20))) berr++;
      if (gd !== ((c == 10) || (c == 20))) berr++;
      if (gd === 1'b1) ndone++;
      if (c == 1) begin
        mode = mb; accumulate = acb; srca = ba; srcb = bb; acc_lo = alo_b; acc_hi = ahi_b;
      end
      if (c == 10) begin
        chk("b2b.a.res", {ghi[31:0], glo[31:0]}, {eahi[31:0], ealo[31:0]});
        chk("b2b.a.flags", 64'(gfl), 64'(eafl));
      end
      if (c == 11) start8 = 1'b0;
      if (c == 20) begin
        chk("b2b.b.res", {ghi[31:0], glo[31:0]}, {ebhi[31:0], eblo[31:0]});
        chk("b2b.b.flags", 64'(gfl), 64'(ebfl));
      end
    end
    chk("b2b.ndone", 64'(ndone), 64'd2);
    chk("b2b.timing", 64'(berr), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits (legal range 4..64, even).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request a new operation.
REQ-005 SHALL have port mode, input, 2 bits: 00 MUL (low word only), 01 UMULL, 10 SMULL, 11 reserved (executes as 01).
REQ-006 SHALL have port accumulate, input, 1 bit: add accumulator (MLA/UMLAL/SMLAL).
REQ-007 SHALL have ports srca and srcb, input, WIDTH bits each: multiplicand and multiplier.
REQ-008 SHALL have ports acc_lo and acc_hi, input, WIDTH bits each: accumulator low/high words.
REQ-009 SHALL have port busy, output, 1 bit: operation in progress, start ignored.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have ports result_lo and result_hi, output, WIDTH bits each: product low word (RdLo) and high word (RdHi).
REQ-012 SHALL have port flags, output, 2 bits: {N,Z} of the completed result.

Function
REQ-013 SHALL implement states IDLE, CALC, FIX, DONE; IDLE->CALC on start, CALC->FIX after WIDTH iterations, FIX->DONE, DONE->IDLE (or ->CALC on start in DONE).
REQ-014 SHALL sample start, mode, accumulate, srca, srcb, acc_lo, acc_hi only on the edge ending an IDLE or DONE cycle with start=1; later input changes have no effect on the running operation.
REQ-015 SHALL, in signed mode, take magnitudes of srca/srcb at start and record sign = sign(srca) XOR sign(srcb); unsigned modes use operands as-is.
REQ-016 SHALL in CALC process one multiplier bit per cycle (radix-2 shift-add into a 2*WIDTH-bit product register), iteration counter 0..WIDTH-1.
REQ-017 SHALL in FIX negate the product (two's complement, 2*WIDTH bits) if recorded sign=1, then add accumulator if accumulate=1: mode 00 adds acc_lo to the low word; long modes add {acc_hi,acc_lo}; all additions modulo 2^(2*WIDTH), carry-out discarded.
REQ-018 SHALL update result_lo, result_hi, flags only at the FIX->DONE edge; values hold until the next FIX->DONE edge.
REQ-019 SHALL in mode 00 drive result_hi = 0, N = result_lo[WIDTH-1], Z = (result_lo==0); in long modes N = result_hi[WIDTH-1], Z = ({result_hi,result_lo}==0).
REQ-020 SHALL drive busy=1 in CALC and FIX, 0 in IDLE and DONE; done=1 only in DONE.
REQ-021 SHALL have fixed latency: start high in cycle 0 (not busy) -> busy in cycles 1..WIDTH+1, done high in cycle WIDTH+2 exactly.
REQ-022 SHALL ignore start while busy=1 (no queuing, no effect on state).
REQ-023 SHALL accept start during the DONE cycle (back-to-back); done still pulses that cycle and the next operation's done occurs WIDTH+2 cycles later.
REQ-024 SHALL handle operand zero, all-ones and most-negative values without special-casing (e.g. SMULL of -2^(WIDTH-1) by itself yields +2^(2*WIDTH-2)).

Reset
REQ-025 SHALL, with reset=1 at a rising edge, enter IDLE and clear busy, done, result_lo, result_hi, flags, product register and counter to 0.
REQ-026 SHALL let reset override start and abort any operation mid-CALC/FIX with no done pulse and no result update.

Verification (WIDTH=32 unless stated)
REQ-027 SHALL cover MUL 7*6, accumulate=0 -> done in cycle 34 only, result_lo=42, result_hi=0, flags=00.
REQ-028 SHALL cover UMULL 0xFFFFFFFF*0xFFFFFFFF -> result_hi=0xFFFFFFFE, result_lo=0x00000001, flags=10.
REQ-029 SHALL cover SMULL 0xFFFFFFFE*3 -> {hi,lo}={0xFFFFFFFF,0xFFFFFFFA}, N=1; then SMLAL same operands with acc {0,6} -> {0,0}, Z=1.
REQ-030 SHALL cover MLA 0x80000000*2 + acc_lo=1 -> result_lo=1 (wrap), result_hi=0.
REQ-031 SHALL cover start pulses in cycles 5 and 20 of a running op -> ignored, single done in cycle 34; reset in cycle 10 of a new op -> busy=0 next cycle, no done, results=0.
REQ-032 SHALL cover WIDTH=8 back-to-back: start held through DONE -> done in cycles 10 and 20, each with correct result.
